// File: rtl/buzzer_sequencer.sv
// buzzer_sequencer: plays a fixed 16-step melody on the one-hot piano input of the buzzer and
// arbitrates that input with the four manual keys. Manual keys always win; autoplay pauses for
// HOLD_CYC cycles after a key and then replays the interrupted step from its start.
// Optional feature: define BUZZER_SEQ_LOOP_EN to loop the melody until play_stop.
module buzzer_sequencer #(
  parameter int unsigned NOTE_CYC = 25_000_000,
  parameter int unsigned HOLD_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  input  logic       play_start,
  input  logic       play_stop,
  output logic [3:0] pianos_out,
  output logic       busy,
  output logic [3:0] note_idx
);

  typedef enum logic [1:0] {StIdle, StPlay, StHold} state_e;

  localparam logic [31:0] NoteLast = 32'(NOTE_CYC - 1);
  localparam logic [31:0] HoldLast = 32'(HOLD_CYC - 1);

`ifdef BUZZER_SEQ_LOOP_EN
  localparam bit LoopEn = 1'b1;
`else
  localparam bit LoopEn = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] slot_q, slot_d;
  logic [31:0] hold_q, hold_d;
  logic [3:0]  pianos_d;
  logic        busy_d;

  logic key_ok;
  logic slot_end;
  logic hold_end;
  logic song_end;

  // Melody ROM: 0 = rest, 1..4 = Do..Fa.
  function automatic logic [2:0] rom_code(input logic [3:0] i);
    case (i)
      4'd0, 4'd4, 4'd3, 4'd7: rom_code = 3'd1;
      4'd1, 4'd5:             rom_code = 3'd2;
      4'd2, 4'd6, 4'd8, 4'd12: rom_code = 3'd3;
      4'd9, 4'd13:            rom_code = 3'd4;
      default:                rom_code = 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] rom_note(input logic [3:0] i);
    logic [2:0] code;
    code = rom_code(i);
    rom_note = (code == 3'd0) ? 4'b0000 : 4'(4'b0001 << (code - 3'd1));
  endfunction

  // Decode helpers for the current cycle.
  always_comb begin
    key_ok   = (key_in != 4'b0000) && ((key_in & (key_in - 4'd1)) == 4'b0000);
    slot_end = (state_q == StPlay) && (slot_q == NoteLast);
    hold_end = (state_q == StHold) && (hold_q == HoldLast);
    song_end = slot_end && (idx_q == 4'd15) && !LoopEn;
  end

  // Next state: sequencer step first, then overrides in rising priority (start, key, stop).
  // A sequencer note is emitted on the same edge that opens its slot (slot_cnt becomes 0).
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    slot_d   = slot_q;
    hold_d   = hold_q;
    pianos_d = 4'b0000;

    unique case (state_q)
      StIdle: ;
      StPlay: begin
        if (slot_end) begin
          slot_d = 32'd0;
          if (song_end) begin
            state_d = StIdle;
            idx_d   = 4'd0;
          end else begin
            idx_d    = idx_q + 4'd1;  // wraps 15 -> 0 in the looping build
            pianos_d = rom_note(idx_q + 4'd1);
          end
        end else begin
          slot_d = slot_q + 32'd1;
        end
      end
      StHold: begin
        if (hold_end) begin
          state_d  = StPlay;
          slot_d   = 32'd0;
          hold_d   = 32'd0;
          pianos_d = rom_note(idx_q);
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (play_start) begin
      state_d  = StPlay;
      idx_d    = 4'd0;
      slot_d   = 32'd0;
      hold_d   = 32'd0;
      pianos_d = rom_note(4'd0);
    end

    // A key pre-empts any note opening this cycle; idx stays on that step so it replays.
    if (key_ok) begin
      pianos_d = key_in;
      if (state_q != StIdle || play_start) begin
        state_d = StHold;
        hold_d  = 32'd0;
        slot_d  = 32'd0;
        if (song_end && !play_start) idx_d = idx_q;
      end
    end

    if (play_stop) begin
      state_d  = StIdle;
      idx_d    = 4'd0;
      slot_d   = 32'd0;
      hold_d   = 32'd0;
      pianos_d = key_ok ? key_in : 4'b0000;
    end

    busy_d = (state_d != StIdle);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= 4'd0;
      slot_q     <= 32'd0;
      hold_q     <= 32'd0;
      pianos_out <= 4'b0000;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      slot_q     <= slot_d;
      hold_q     <= hold_d;
      pianos_out <= pianos_d;
      busy       <= busy_d;
    end
  end

  assign note_idx = idx_q;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed bench for buzzer_sequencer: expected pulses (cycle, value) are queued when stimulus
// is driven and matched against every nonzero pianos_out seen on the falling edge.
module tb_buzzer_sequencer;

  localparam int unsigned NoteCyc = 8;
  localparam int unsigned HoldCyc = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_in = 4'b0000;
  logic       play_start = 1'b0;
  logic       play_stop = 1'b0;
  logic [3:0] pianos_out;
  logic       busy;
  logic [3:0] note_idx;

  buzzer_sequencer #(
    .NOTE_CYC(NoteCyc),
    .HOLD_CYC(HoldCyc)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .play_start(play_start),
    .play_stop (play_stop),
    .pianos_out(pianos_out),
    .busy      (busy),
    .note_idx  (note_idx)
  );

  always #5 clk = ~clk;

  // Edge counter: outputs produced by edge k are sampled at the negedge where cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         at;
    logic [3:0] val;
  } exp_t;
  exp_t sb[$];

  logic [2:0] song [16] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd1, 3'd2, 3'd3, 3'd1,
                            3'd3, 3'd4, 3'd0, 3'd0, 3'd3, 3'd4, 3'd0, 3'd0};

  function automatic logic [3:0] onehot_of(input logic [2:0] c);
    onehot_of = (c == 3'd0) ? 4'b0000 : 4'(4'b0001 << (c - 3'd1));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int at, input logic [3:0] val);
    exp_t e;
    e.at  = at;
    e.val = val;
    sb.push_back(e);
  endtask

  // Scoreboard: every pulse must match the head of the queue; overdue entries are misses.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at < cyc) begin
      check("missed_pulse_at", 32'(cyc), 32'(sb[0].at));
      void'(sb.pop_front());
    end
    if (pianos_out !== 4'b0000) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(pianos_out), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e.at));
        check("pulse_value", 32'(pianos_out), 32'(e.val));
      end
    end
  end

  // Return where the next posedge is edge k.
  task automatic goto_edge(input int k);
    while (cyc < k - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int k, input logic st, input logic sp, input logic [3:0] key);
    goto_edge(k);
    play_start = st;
    play_stop  = sp;
    key_in     = key;
    @(posedge clk);
    #1;
    play_start = 1'b0;
    play_stop  = 1'b0;
    key_in     = 4'b0000;
  endtask

  task automatic wait_to(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int s;
    int k;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("reset_pianos", 32'(pianos_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_idx", 32'(note_idx), 32'd0);
    rst_n = 1'b1;

    // Full song.
    s = cyc + 3;
    for (int n = 0; n < 16; n++) begin
      if (song[n] != 3'd0) push(s + n * NoteCyc, onehot_of(song[n]));
    end
`ifdef BUZZER_SEQ_LOOP_EN
    push(s + 16 * NoteCyc, 4'b0001);
`endif
    drive(s, 1'b1, 1'b0, 4'b0000);
    wait_to(s);
    check("song_busy_rise", 32'(busy), 32'd1);
    check("song_idx0", 32'(note_idx), 32'd0);
    wait_to(s + 9 * NoteCyc + 2);
    check("song_idx9", 32'(note_idx), 32'd9);
    wait_to(s + 127);
    check("song_busy_before_end", 32'(busy), 32'd1);
    wait_to(s + 128);
`ifdef BUZZER_SEQ_LOOP_EN
    check("loop_busy_stays", 32'(busy), 32'd1);
    check("loop_idx_wrap", 32'(note_idx), 32'd0);
    drive(s + 130, 1'b0, 1'b1, 4'b0000);
`else
    check("song_busy_fall", 32'(busy), 32'd0);
    check("song_idx_cleared", 32'(note_idx), 32'd0);
`endif
    wait_to(s + 145);
    check("song_drain", 32'(sb.size()), 32'd0);

    // Key during PLAY: pause, then step 0 replays HOLD_CYC after the key.
    s = cyc + 3;
    push(s, 4'b0001);
    push(s + 3, 4'b0100);
    push(s + 3 + HoldCyc, 4'b0001);
    drive(s, 1'b1, 1'b0, 4'b0000);
    drive(s + 3, 1'b0, 1'b0, 4'b0100);
    wait_to(s + 3);
    check("key_busy", 32'(busy), 32'd1);
    wait_to(s + 10);
    check("key_hold_idx", 32'(note_idx), 32'd0);
    wait_to(s + 15);
    check("key_replay_idx", 32'(note_idx), 32'd0);
    drive(s + 20, 1'b0, 1'b1, 4'b0000);
    wait_to(s + 20);
    check("key_stop_busy", 32'(busy), 32'd0);
    wait_to(s + 35);
    check("key_drain", 32'(sb.size()), 32'd0);

    // Second key during HOLD restarts the pause.
    s = cyc + 3;
    push(s, 4'b0001);
    push(s + 3, 4'b0100);
    push(s + 9, 4'b1000);
    push(s + 9 + HoldCyc, 4'b0001);
    drive(s, 1'b1, 1'b0, 4'b0000);
    drive(s + 3, 1'b0, 1'b0, 4'b0100);
    drive(s + 9, 1'b0, 1'b0, 4'b1000);
    drive(s + 24, 1'b0, 1'b1, 4'b0000);
    wait_to(s + 40);
    check("rehold_drain", 32'(sb.size()), 32'd0);

    // Collision: key on the edge that would emit step 1; step 1 replays after the hold.
    s = cyc + 3;
    push(s, 4'b0001);
    push(s + NoteCyc, 4'b1000);
    push(s + NoteCyc + HoldCyc, 4'b0010);
    drive(s, 1'b1, 1'b0, 4'b0000);
    drive(s + NoteCyc, 1'b0, 1'b0, 4'b1000);
    wait_to(s + NoteCyc);
    check("coll_idx", 32'(note_idx), 32'd1);
    wait_to(s + NoteCyc + HoldCyc);
    check("coll_replay_idx", 32'(note_idx), 32'd1);
    drive(s + 24, 1'b0, 1'b1, 4'b0000);
    wait_to(s + 40);
    check("coll_drain", 32'(sb.size()), 32'd0);

    // Invalid key in IDLE, valid key in IDLE.
    k = cyc + 3;
    drive(k, 1'b0, 1'b0, 4'b0011);
    wait_to(k);
    check("idle_invalid_key", 32'(pianos_out), 32'd0);
    k = cyc + 3;
    push(k, 4'b0001);
    drive(k, 1'b0, 1'b0, 4'b0001);
    wait_to(k);
    check("idle_key_busy", 32'(busy), 32'd0);
    wait_to(k + 1);
    check("idle_key_one_wide", 32'(pianos_out), 32'd0);
    check("idle_key_busy_after", 32'(busy), 32'd0);

    // Invalid key during PLAY has no effect on the sequence.
    s = cyc + 3;
    push(s, 4'b0001);
    push(s + NoteCyc, 4'b0010);
    drive(s, 1'b1, 1'b0, 4'b0000);
    drive(s + 3, 1'b0, 1'b0, 4'b1100);
    drive(s + 10, 1'b0, 1'b1, 4'b0000);
    wait_to(s + 25);
    check("play_invalid_drain", 32'(sb.size()), 32'd0);

    // Stop during step 5.
    s = cyc + 3;
    for (int n = 0; n < 6; n++) push(s + n * NoteCyc, onehot_of(song[n]));
    drive(s, 1'b1, 1'b0, 4'b0000);
    drive(s + 43, 1'b0, 1'b1, 4'b0000);
    wait_to(s + 43);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_idx", 32'(note_idx), 32'd0);
    wait_to(s + 70);
    check("stop_drain", 32'(sb.size()), 32'd0);

    // Reset mid-song, asserted while the step-1 pulse is on the output.
    s = cyc + 3;
    push(s, 4'b0001);
    drive(s, 1'b1, 1'b0, 4'b0000);
    goto_edge(s + NoteCyc + 1);
    rst_n = 1'b0;
    #1;
    check("rst_pianos", 32'(pianos_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_idx", 32'(note_idx), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = cyc + 20;
    wait_to(k);
    check("rst_release_busy", 32'(busy), 32'd0);
    check("rst_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
